pt2262_encoder: RTL and testbench
=================================

PT2262_ENCODER -- requirements
Module: pt2262_encoder

Interface
REQ-001 Parameter N_BITS, default 12: number of tri-state code symbols per frame; legal range 1..32.
REQ-002 Parameter DIV, default 1: clk cycles per oscillator tick (alpha); legal range 1..65535.
REQ-003 Parameter REPEATS, default 4: frames sent per accepted start; legal range 1..255.
REQ-004 clk  input  1  single clock; all logic updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request to transmit; sampled every cycle.
REQ-007 code  input  2*N_BITS  symbol k occupies bits [2k+1:2k]; encoding 00=zero, 01=one, 10=float, 11=float.
REQ-008 busy  output  1  high while a transmission is in progress.
REQ-009 done  output  1  single-cycle completion pulse.
REQ-010 q  output  1  encoded serial waveform.

Function
REQ-011 States: IDLE, BIT, SYNC; reset state is IDLE.
- IDLE -> BIT on start=1.
- BIT -> SYNC after symbol 0.
- SYNC -> BIT at the end of a sync period while frames remain.
- SYNC -> IDLE after the last frame.
REQ-012 start=1 in IDLE SHALL latch code into an internal register in that same cycle; later changes to code SHALL NOT affect the transmission in progress.
REQ-013 busy and the first output tick SHALL begin in the cycle after start is accepted (latency 1).
REQ-014 start while busy=1 SHALL be ignored; no queueing.
REQ-015 Frame structure:
- symbols in order N_BITS-1 down to 0;
- then one sync period;
- total frame length (32*N_BITS+128) ticks.
REQ-016 Each tick SHALL last exactly DIV clk cycles; q changes only on tick boundaries.
REQ-017 Each symbol is 32 ticks, made of two 16-tick halves.
- A short half is 4 ticks high then 12 low.
- A long half is 12 ticks high then 4 low.
REQ-018 Half usage per symbol:
- zero = short, short;
- one = long, long;
- float (10 or 11) = short, long.
REQ-019 Sync period SHALL be 4 ticks high then 124 ticks low.
REQ-020 REPEATS frames SHALL be sent back to back with no gap; total busy duration = REPEATS*(32*N_BITS+128)*DIV cycles.
REQ-021 In the last cycle of the last sync period:
- busy SHALL be 1;
- done SHALL be 0.
REQ-022 In the following cycle: busy=0, done=1, q=0; done SHALL return to 0 one cycle later.
REQ-023 start=1 in the cycle where done=1 SHALL be accepted, so back-to-back transmissions are possible.
REQ-024 q SHALL be 0 whenever busy=0.
REQ-025 Counters SHALL be sized with $clog2 of their maximum count and SHALL never wrap within a frame.

Reset
REQ-026 rst=1 SHALL, at the next rising edge, force state=IDLE, busy=0, done=0 and q=0, and clear all counters.
REQ-027 rst SHALL take priority over start.
REQ-028 Reset mid-frame SHALL abort the frame with no done pulse.
REQ-029 The first start accepted after rst falls SHALL produce a complete, normally timed transmission.

Configuration
REQ-030 Macro PT2262_LOOP_EN.
- When defined: add input hold (1 bit).
- If hold=1 at the end of the last repeat, the block SHALL restart at frame 1 using the same latched code, with no gap and no done pulse.
- If hold=0 at that point, the block SHALL finish normally.
REQ-031 When PT2262_LOOP_EN is not defined: the hold port SHALL NOT exist, and behaviour SHALL be exactly as REQ-011..REQ-029.

Verification
REQ-032 Scenario 1, all-zero code.
- Setup: N_BITS=12, DIV=1, REPEATS=1, code=0.
- Each symbol: q high 4 cycles, low 12, high 4, low 12.
- Sync: q high 4 cycles, low 124.
- busy lasts 512 cycles; done pulses at cycle 513 after start.
REQ-033 Scenario 2, mixed symbols.
- Setup: DIV=3, code symbol 11 = 01, symbol 10 = 10, symbol 9 = 11.
- Symbol 11: q high 36 cycles, low 12, high 36, low 12.
- Symbols 10 and 9: each q high 12 cycles, low 36, high 36, low 12.
REQ-034 Scenario 3, start while busy and code change.
- Setup: REPEATS=4.
- Pulse start again mid-transmission and change code at the same time.
- Exactly 4 identical frames result; done pulses once, after 2048*DIV cycles.
REQ-035 Scenario 4, reset mid-operation.
- Assert rst at tick 100 of frame 2.
- Next edge: q=0, busy=0, and no done pulse.
- A new start then yields a full 4-frame transmission.
REQ-036 Scenario 5, loop mode (PT2262_LOOP_EN defined).
- Hold hold=1 for 10 frames, then drop it.
- q is continuous for 12 frames, which completes the current repeat block.
- Exactly one done pulse occurs at the end.

Source files
------------

// File: rtl/pt2262_encoder.sv
// PT2262-style tri-state remote-control encoder: serialises a latched symbol word into repeated frames.
// Optional loop-while-held mode is compiled in with `define PT2262_LOOP_EN, which adds input hold.
module pt2262_encoder #(
    parameter int N_BITS  = 12,
    parameter int DIV     = 1,
    parameter int REPEATS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [2*N_BITS-1:0] code,
`ifdef PT2262_LOOP_EN
    input  logic                hold,
`endif
    output logic                busy,
    output logic                done,
    output logic                q,
    output logic [1:0]          state_dbg
);
    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SYM_W  = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam int REP_W  = (REPEATS > 1) ? $clog2(REPEATS) : 1;
    localparam int TICK_W = $clog2(128);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [SYM_W-1:0]  SYM_LAST  = SYM_W'(N_BITS - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEATS - 1);
    localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(31);
    localparam logic [TICK_W-1:0] SYNC_LAST = TICK_W'(127);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BIT  = 2'd1,
        SYNC = 2'd2
    } state_t;

    state_t              state, nxt_state;
    logic [DIV_W-1:0]    div_cnt, nxt_div;
    logic [TICK_W-1:0]   tick_cnt, nxt_tick;
    logic [SYM_W-1:0]    sym_idx, nxt_sym;
    logic [REP_W-1:0]    rep_cnt, nxt_rep;
    logic [2*N_BITS-1:0] code_r, nxt_code;
    logic                nxt_done;
    logic                nxt_q;
    logic [1:0]          nxt_sv;
    logic                nxt_long;
    logic                tick_end;
    logic                loop_req;

`ifdef PT2262_LOOP_EN
    assign loop_req = hold;
`else
    assign loop_req = 1'b0;
`endif

    assign tick_end  = (div_cnt == DIV_LAST);
    assign state_dbg = state;

    function automatic logic [1:0] sym_code(input logic [2*N_BITS-1:0] c,
                                            input logic [SYM_W-1:0]    s);
        sym_code = 2'b00;
        for (int k = 0; k < N_BITS; k++) begin
            if (s == SYM_W'(k)) sym_code = c[2*k +: 2];
        end
    endfunction

    // Next position in the frame; counters describe the tick currently on q.
    always_comb begin
        nxt_state = state;
        nxt_div   = div_cnt;
        nxt_tick  = tick_cnt;
        nxt_sym   = sym_idx;
        nxt_rep   = rep_cnt;
        nxt_code  = code_r;
        nxt_done  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    nxt_state = BIT;
                    nxt_div   = '0;
                    nxt_tick  = '0;
                    nxt_sym   = SYM_LAST;
                    nxt_rep   = '0;
                    nxt_code  = code;
                end
            end
            BIT: begin
                if (tick_end) begin
                    nxt_div = '0;
                    if (tick_cnt == BIT_LAST) begin
                        nxt_tick = '0;
                        if (sym_idx == '0) nxt_state = SYNC;
                        else               nxt_sym   = sym_idx - 1'b1;
                    end else begin
                        nxt_tick = tick_cnt + 1'b1;
                    end
                end else begin
                    nxt_div = div_cnt + 1'b1;
                end
            end
            SYNC: begin
                if (tick_end) begin
                    nxt_div = '0;
                    if (tick_cnt == SYNC_LAST) begin
                        nxt_tick = '0;
                        if (rep_cnt == REP_LAST) begin
                            if (loop_req) begin
                                nxt_state = BIT;
                                nxt_sym   = SYM_LAST;
                                nxt_rep   = '0;
                            end else begin
                                nxt_state = IDLE;
                                nxt_done  = 1'b1;
                            end
                        end else begin
                            nxt_state = BIT;
                            nxt_sym   = SYM_LAST;
                            nxt_rep   = rep_cnt + 1'b1;
                        end
                    end else begin
                        nxt_tick = tick_cnt + 1'b1;
                    end
                end else begin
                    nxt_div = div_cnt + 1'b1;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    // Waveform level for the next position: every half starts high, long halves stay high 12 of 16 ticks.
    always_comb begin
        nxt_sv   = sym_code(nxt_code, nxt_sym);
        nxt_long = (nxt_sv == 2'b01) || (nxt_sv[1] && nxt_tick[4]);
        case (nxt_state)
            BIT:     nxt_q = nxt_long ? (nxt_tick[3:0] < 4'd12) : (nxt_tick[3:0] < 4'd4);
            SYNC:    nxt_q = (nxt_tick < TICK_W'(4));
            default: nxt_q = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            div_cnt  <= '0;
            tick_cnt <= '0;
            sym_idx  <= '0;
            rep_cnt  <= '0;
            code_r   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            q        <= 1'b0;
        end else begin
            state    <= nxt_state;
            div_cnt  <= nxt_div;
            tick_cnt <= nxt_tick;
            sym_idx  <= nxt_sym;
            rep_cnt  <= nxt_rep;
            code_r   <= nxt_code;
            busy     <= (nxt_state != IDLE);
            done     <= nxt_done;
            q        <= nxt_q;
        end
    end
endmodule

// File: tb/tb_pt2262_encoder.sv
// Bench for pt2262_encoder: instance A (DIV=1, REPEATS=1) and instance B (DIV=3, REPEATS=4),
// table-driven run-length vectors plus full-waveform comparison against a reference model.
module tb_pt2262_encoder;
    localparam int N    = 12;
    localparam int MAXC = 20000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, sel;
    logic [2*N-1:0] code;
    logic          a_start, b_start;
    logic          a_busy, a_done, a_q, b_busy, b_done, b_q;
    logic [1:0]    a_state, b_state;
    logic          mq, mb, md;
`ifdef PT2262_LOOP_EN
    logic          hold;
`endif

    assign a_start = start & ~sel;
    assign b_start = start & sel;
    assign mq = sel ? b_q : a_q;
    assign mb = sel ? b_busy : a_busy;
    assign md = sel ? b_done : a_done;

    pt2262_encoder #(.N_BITS(N), .DIV(1), .REPEATS(1)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .code(code),
`ifdef PT2262_LOOP_EN
        .hold(1'b0),
`endif
        .busy(a_busy), .done(a_done), .q(a_q), .state_dbg(a_state)
    );

    pt2262_encoder #(.N_BITS(N), .DIV(3), .REPEATS(4)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .code(code),
`ifdef PT2262_LOOP_EN
        .hold(hold),
`endif
        .busy(b_busy), .done(b_done), .q(b_q), .state_dbg(b_state)
    );

    typedef struct {
        int sel;
        int sym;   // -1 selects the sync period
        int r0, r1, r2, r3;
    } vec_t;
    vec_t vecs[10];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_cap;
    logic q_log    [0:MAXC];
    logic busy_log [0:MAXC];
    logic done_log [0:MAXC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference level of q in busy cycle n (1-based) for a 12-symbol frame.
    function automatic logic model_q(input logic [23:0] c, input int n, input int div);
        int ft, sym, t;
        logic [1:0] sv;
        logic lng;
        ft = ((n - 1) / div) % 512;
        if (ft >= 384) return ((ft - 384) < 4);
        sym = 11 - ft / 32;
        t   = ft % 32;
        sv  = c[2*sym +: 2];
        lng = (sv == 2'b01) || (sv[1] && t >= 16);
        return lng ? ((t % 16) < 12) : ((t % 16) < 4);
    endfunction

    // Lengths of the high/low/high/low runs starting at busy cycle s, within len cycles.
    function automatic logic [63:0] runs_at(input int s, input int len);
        int p, cnt;
        logic [63:0] r;
        p = s;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            cnt = 0;
            while (p < s + len && q_log[p] == ((k % 2) == 0)) begin
                cnt++;
                p++;
            end
            r = {r[47:0], cnt[15:0]};
        end
        return r;
    endfunction

    task automatic pulse_start(input logic [23:0] c);
        @(negedge clk);
        code  = c;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic capture(input int budget, input int poke_at, input logic [23:0] poke_code,
                           input bit restart, input logic [23:0] next_code, input int hold_drop);
        bit seen;
        seen  = 1'b0;
        n_cap = 0;
        while (!seen && n_cap < budget) begin
            @(negedge clk);
            n_cap++;
            q_log[n_cap]    = mq;
            busy_log[n_cap] = mb;
            done_log[n_cap] = md;
            start = 1'b0;
            if (n_cap == poke_at) begin
                start = 1'b1;
                code  = poke_code;
            end
`ifdef PT2262_LOOP_EN
            if (n_cap == hold_drop) hold = 1'b0;
`endif
            if (md === 1'b1) begin
                seen = 1'b1;
                if (restart) begin
                    start = 1'b1;
                    code  = next_code;
                end
            end
        end
    endtask

    task automatic check_tx(input string name, input logic [23:0] c, input int div,
                            input int total, input bit post);
        int errs, first;
        errs  = 0;
        first = 0;
        check({name, "_done_cycle"}, n_cap, total + 1);
        for (int n = 1; n < n_cap && n <= total; n++) begin
            if (busy_log[n] !== 1'b1 || done_log[n] !== 1'b0 || q_log[n] !== model_q(c, n, div)) begin
                errs++;
                if (first == 0) first = n;
            end
        end
        if (errs != 0) $display("  first bad cycle in %s: %0d", name, first);
        check({name, "_wave_errs"}, errs, 0);
        check({name, "_busy_at_done"}, busy_log[n_cap], 0);
        check({name, "_q_at_done"}, q_log[n_cap], 0);
        if (post) begin
            @(negedge clk);
            check({name, "_done_after"}, md, 0);
            check({name, "_busy_after"}, mb, 0);
            check({name, "_q_after"}, mq, 0);
        end
    endtask

    task automatic check_table(input int s, input int div);
        int st, len;
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].sel == s) begin
                if (vecs[i].sym >= 0) begin
                    st  = 1 + (N - 1 - vecs[i].sym) * 32 * div;
                    len = 32 * div;
                end else begin
                    st  = 1 + 32 * N * div;
                    len = 128 * div;
                end
                check($sformatf("runs_sel%0d_sym%0d", s, vecs[i].sym), runs_at(st, len),
                      {vecs[i].r0[15:0], vecs[i].r1[15:0], vecs[i].r2[15:0], vecs[i].r3[15:0]});
            end
        end
    endtask

    initial begin
        int dones;
        rst   = 1'b1;
        start = 1'b0;
        sel   = 1'b0;
        code  = '0;
`ifdef PT2262_LOOP_EN
        hold  = 1'b0;
`endif
        vecs[0] = '{0, 11, 4, 12, 4, 12};
        vecs[1] = '{0, 0, 4, 12, 4, 12};
        vecs[2] = '{0, -1, 4, 124, 0, 0};
        vecs[3] = '{1, 11, 36, 12, 36, 12};
        vecs[4] = '{1, 10, 12, 36, 36, 12};
        vecs[5] = '{1, 9, 12, 36, 36, 12};
        vecs[6] = '{1, 8, 12, 36, 12, 36};
        vecs[7] = '{1, 1, 12, 36, 36, 12};
        vecs[8] = '{1, 0, 36, 12, 36, 12};
        vecs[9] = '{1, -1, 12, 372, 0, 0};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_a_busy", a_busy, 0);
        check("rst_a_done", a_done, 0);
        check("rst_a_q", a_q, 0);
        check("rst_a_state", a_state, 0);
        check("rst_b_busy", b_busy, 0);
        check("rst_b_done", b_done, 0);
        check("rst_b_q", b_q, 0);
        check("rst_b_state", b_state, 0);
        rst = 1'b0;

        // All-zero code, single frame, DIV=1
        sel = 1'b0;
        pulse_start(24'h000000);
        capture(600, -1, '0, 1'b0, '0, -1);
        check_tx("zero_code", 24'h000000, 1, 512, 1'b1);
        check_table(0, 1);

        // Back-to-back: start in the done cycle is accepted
        pulse_start(24'h123456);
        capture(600, -1, '0, 1'b1, 24'hFEDCBA, -1);
        check_tx("b2b_first", 24'h123456, 1, 512, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        capture(600, -1, '0, 1'b0, '0, -1);
        check_tx("b2b_second", 24'hFEDCBA, 1, 512, 1'b1);

        // Reset wins over start
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        code  = 24'hFFFFFF;
        @(negedge clk);
        check("rst_prio_busy", a_busy, 0);
        check("rst_prio_state", a_state, 0);
        rst   = 1'b0;
        start = 1'b0;

        // Mixed symbols, DIV=3, four frames
        sel = 1'b1;
        pulse_start(24'h6CAAA9);
        capture(6200, -1, '0, 1'b0, '0, -1);
        check_tx("mixed", 24'h6CAAA9, 3, 6144, 1'b1);
        check_table(1, 3);

        // Start and code change while busy are ignored
        pulse_start(24'h5A0F33);
        capture(6200, 2000, 24'hFFFFFF, 1'b0, '0, -1);
        check_tx("start_busy", 24'h5A0F33, 3, 6144, 1'b1);

        // Reset at tick 100 of frame 2
        pulse_start(24'hA5C3F0);
        repeat (1837) @(negedge clk);
        check("mid_busy", b_busy, 1);
        check("mid_state", b_state, 1);
        check("mid_q", b_q, model_q(24'hA5C3F0, 1837, 3));
        rst = 1'b1;
        @(negedge clk);
        check("abort_q", b_q, 0);
        check("abort_busy", b_busy, 0);
        check("abort_done", b_done, 0);
        check("abort_state", b_state, 0);
        rst   = 1'b0;
        dones = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (b_done === 1'b1) dones++;
        end
        check("abort_no_done", dones, 0);
        pulse_start(24'h0F0F0F);
        capture(6200, -1, '0, 1'b0, '0, -1);
        check_tx("after_abort", 24'h0F0F0F, 3, 6144, 1'b1);

`ifdef PT2262_LOOP_EN
        // Hold for ten frames: the current repeat block of four finishes (12 frames), one done
        hold = 1'b1;
        pulse_start(24'h3C3C3C);
        capture(12 * 1536 + 20, -1, '0, 1'b0, '0, 10 * 1536);
        check_tx("loop", 24'h3C3C3C, 3, 12 * 1536, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
